// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter that shares one FIFO write port among NUM_REQ producers.
// Each grant forwards up to MAX_BURST beats and never writes while the FIFO reports full.
module fifo_wr_arbiter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*WIDTH-1:0]     req_data,
    input  logic                         fifo_full,
    output logic [NUM_REQ-1:0]           ack,
    output logic                         fifo_write,
    output logic [WIDTH-1:0]             fifo_data,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy
);

    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(MAX_BURST + 1);

    typedef enum logic {StIdle, StGrant} state_e;

    state_e            state_q, state_d;
    logic [IdW-1:0]    owner_q, owner_d;
    logic [IdW-1:0]    last_owner_q, last_owner_d;
    logic [CntW-1:0]   beat_cnt_q, beat_cnt_d;

    logic [WIDTH-1:0]  req_slice [NUM_REQ];
    logic              pick_valid;
    logic [IdW-1:0]    pick_idx;
    logic [IdW-1:0]    cand_idx;
    int unsigned       cand;
    logic              beat;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_slice[i] = req_data[i*WIDTH +: WIDTH];
        end
    end

    // Search starts just past the previous owner so it gets the lowest priority.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand     = (32'(last_owner_q) + k) % NUM_REQ;
            cand_idx = IdW'(cand);
            if (!pick_valid && req[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    assign beat = (state_q == StGrant) && req[owner_q] && !fifo_full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            owner_q      <= '0;
            last_owner_q <= IdW'(NUM_REQ - 1);
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
        case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d      = StGrant;
                    owner_d      = pick_idx;
                    last_owner_d = pick_idx;
                    beat_cnt_d   = '0;
                end
            end
            StGrant: begin
                if (!req[owner_q]) begin
                    state_d = StIdle;
                end else if (!fifo_full) begin
                    if (beat_cnt_q == CntW'(MAX_BURST - 1)) begin
                        state_d = StIdle;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CntW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // grant_id reflects the owner register, so it holds the last owner while idle.
    always_comb begin
        ack        = '0;
        fifo_write = 1'b0;
        fifo_data  = '0;
        busy       = 1'b0;
        grant_id   = owner_q;
        if (state_q == StGrant) begin
            busy         = 1'b1;
            fifo_write   = beat;
            ack[owner_q] = beat;
            fifo_data    = req_slice[owner_q];
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: single-owner bursts, round-robin rotation, full stalls,
// early release, priority search order and asynchronous reset mid-burst.
module tb_fifo_wr_arbiter;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned MAX_BURST = 4;

    logic                       clk = 1'b0;
    logic                       reset_n;
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*WIDTH-1:0]   req_data;
    logic                       fifo_full;
    logic [NUM_REQ-1:0]         ack;
    logic                       fifo_write;
    logic [WIDTH-1:0]           fifo_data;
    logic [1:0]                 grant_id;
    logic                       busy;

    int n_checks = 0;
    int n_errors = 0;
    int w0       = 0;

    fifo_wr_arbiter #(
        .WIDTH     (WIDTH),
        .NUM_REQ   (NUM_REQ),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .req_data   (req_data),
        .fifo_full  (fifo_full),
        .ack        (ack),
        .fifo_write (fifo_write),
        .fifo_data  (fifo_data),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_data(input int i, input logic [WIDTH-1:0] v);
        req_data[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic check_beat(input string tag, input int id, input logic [WIDTH-1:0] d);
        logic [NUM_REQ-1:0] exp_ack;
        exp_ack     = '0;
        exp_ack[id] = 1'b1;
        check_eq({tag, "_busy"}, 32'(busy), 1);
        check_eq({tag, "_gid"}, 32'(grant_id), 32'(id));
        check_eq({tag, "_wr"}, 32'(fifo_write), 1);
        check_eq({tag, "_ack"}, 32'(ack), 32'(exp_ack));
        check_eq({tag, "_data"}, 32'(fifo_data), 32'(d));
    endtask

    task automatic check_stall(input string tag, input int id);
        check_eq({tag, "_busy"}, 32'(busy), 1);
        check_eq({tag, "_gid"}, 32'(grant_id), 32'(id));
        check_eq({tag, "_wr"}, 32'(fifo_write), 0);
        check_eq({tag, "_ack"}, 32'(ack), 0);
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_wr"}, 32'(fifo_write), 0);
        check_eq({tag, "_ack"}, 32'(ack), 0);
        check_eq({tag, "_data"}, 32'(fifo_data), 0);
    endtask

    initial begin
        reset_n   = 1'b0;
        req       = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        #2;
        check_idle("rst");
        check_eq("rst_gid", 32'(grant_id), 0);

        // 1: single requester, 3 beats then release
        tick();
        reset_n = 1'b1;
        req     = 4'b0001;
        set_data(0, 8'h11);
        settle();
        check_idle("t1_arb");
        tick();
        check_beat("t1_b0", 0, 8'h11);
        set_data(0, 8'h22);
        tick();
        settle();
        check_beat("t1_b1", 0, 8'h22);
        set_data(0, 8'h33);
        tick();
        settle();
        check_beat("t1_b2", 0, 8'h33);
        tick();
        req = 4'b0000;
        settle();
        check_stall("t1_rel", 0);
        tick();
        check_idle("t1_end");
        check_eq("t1_gid_hold", 32'(grant_id), 0);

        // 2: all requesting, full rotation with one bubble per grant
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_data(i, 8'hA0 + 8'(i));
        req = 4'b1111;
        settle();
        for (int g = 0; g < 5; g++) begin
            check_idle($sformatf("t2_bub%0d", g));
            tick();
            for (int b = 0; b < MAX_BURST; b++) begin
                settle();
                check_beat($sformatf("t2_g%0d_b%0d", g, b), g % NUM_REQ, 8'hA0 + 8'(g % NUM_REQ));
                tick();
            end
        end
        req = 4'b0000;
        settle();
        check_idle("t2_end");
        tick();

        // 3: owner 1 stalled by full for 5 cycles mid-burst
        req = 4'b0010;
        set_data(1, 8'h51);
        tick();
        settle();
        check_beat("t3_b0", 1, 8'h51);
        tick();
        settle();
        check_beat("t3_b1", 1, 8'h51);
        tick();
        fifo_full = 1'b1;
        for (int s = 0; s < 5; s++) begin
            settle();
            check_stall($sformatf("t3_st%0d", s), 1);
            tick();
        end
        fifo_full = 1'b0;
        settle();
        check_beat("t3_b2", 1, 8'h51);
        tick();
        settle();
        check_beat("t3_b3", 1, 8'h51);
        tick();
        req = 4'b0000;
        settle();
        check_idle("t3_end");
        tick();

        // 4: owner 0 releases after 2 beats, waiting requester 2 takes over
        req = 4'b0001;
        set_data(0, 8'h60);
        set_data(2, 8'h62);
        tick();
        req = 4'b0101;
        settle();
        check_beat("t4_b0", 0, 8'h60);
        w0 += int'(ack[0]);
        tick();
        settle();
        check_beat("t4_b1", 0, 8'h60);
        w0 += int'(ack[0]);
        tick();
        req = 4'b0100;
        settle();
        check_stall("t4_rel", 0);
        w0 += int'(ack[0]);
        tick();
        settle();
        check_idle("t4_bub");
        tick();
        settle();
        check_beat("t4_g2", 2, 8'h62);
        check_eq("t4_w0", 32'(w0), 2);
        req = 4'b0000;
        settle();
        check_stall("t4_rel2", 2);
        tick();

        // 5: last_owner=2, req=1010 -> 3 first, then 1
        req = 4'b1010;
        set_data(1, 8'h71);
        set_data(3, 8'h73);
        settle();
        check_idle("t5_arb");
        tick();
        settle();
        check_beat("t5_g3", 3, 8'h73);
        req = 4'b0010;
        settle();
        tick();
        settle();
        check_idle("t5_bub");
        tick();
        settle();
        check_beat("t5_g1", 1, 8'h71);

        // 6: asynchronous reset between edges mid-burst
        #1;
        reset_n = 1'b0;
        #1;
        check_idle("t6_rst");
        check_eq("t6_gid", 32'(grant_id), 0);
        #1;
        reset_n = 1'b1;
        req     = 4'b1111;
        set_data(0, 8'h80);
        settle();
        check_idle("t6_arb");
        tick();
        settle();
        check_beat("t6_g0", 0, 8'h80);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
